clk_period_gen: RTL and testbench

Synthesizable programmable clock-waveform generator. It is the driving end of the clock-period checks used in our benches. It produces a derived clock `clk_out` with a programmable high time and low time, both counted in `clk` cycles. It also emits single-cycle rise and fall strobes that the period checkers sample. New waveform settings arrive through a valid/ready handshake and take effect only on a period boundary, so `clk_out` never glitches.

---
 rtl/clk_period_gen.sv | 187 ++++++++++++++++++
 tb/tb_clk_period_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_gen.sv
// -----------------------------------------------------------------------------
// clk_period_gen
//
// Programmable clock-waveform generator. Produces clk_out with a high time of
// act_high and a low time of act_low cycles of clk. Single-cycle rise/fall
// strobes accompany every edge of clk_out. New high/low counts are offered
// through a valid/ready handshake. They are held in a one-deep pending slot
// and only take effect when the generator enters its high phase, so clk_out
// never glitches.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active-low
//   en          generator enable (sampled at period boundaries)
//   cfg_valid   new high/low setting is offered
//   cfg_ready   pending-config slot is free
//   cfg_high    requested high time in cycles (0 is treated as 1)
//   cfg_low     requested low time in cycles (0 is treated as 1)
//   clk_out     generated clock
//   rise_pulse  one-cycle strobe coincident with clk_out going 0->1
//   fall_pulse  one-cycle strobe coincident with clk_out going 1->0
//   cur_period  act_high + act_low of the active setting
//   busy        generator is in its high or low phase
// -----------------------------------------------------------------------------
module clk_period_gen #(
    parameter int CNT_W    = 16,
    parameter int DEF_HIGH = 10,
    parameter int DEF_LOW  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W:0]   cur_period,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_HIGH_C = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] DEF_LOW_C  = CNT_W'(DEF_LOW);
    localparam logic [CNT_W:0]   DEF_PERIOD = {1'b0, DEF_HIGH_C} + {1'b0, DEF_LOW_C};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] act_high_r;
    logic [CNT_W-1:0] act_low_r;
    logic [CNT_W-1:0] pend_high_r;
    logic [CNT_W-1:0] pend_low_r;
    logic             pend_valid_r;

    logic             accept_s;
    logic             cnt_zero_s;
    logic             enter_high_s;
    logic             apply_s;
    logic [CNT_W-1:0] high_sel_s;

    // A zero count would make a phase vanish; the shortest legal phase is 1.
    function automatic logic [CNT_W-1:0] clamp_min1(input logic [CNT_W-1:0] v);
        return (v == CNT_ZERO) ? CNT_ONE : v;
    endfunction

    // Decode handshake acceptance, high-phase entry and the apply point.
    always_comb begin
        accept_s     = cfg_valid && cfg_ready;
        cnt_zero_s   = (cnt_r == CNT_ZERO);
        enter_high_s = 1'b0;
        case (state_r)
            ST_IDLE: enter_high_s = en;
            ST_HIGH: enter_high_s = 1'b0;
            ST_LOW:  enter_high_s = cnt_zero_s && en;
            default: enter_high_s = 1'b0;
        endcase
        // accept_s needs an empty slot and apply_s a full one, so a config
        // accepted on a high-entry edge is never applied on that same edge.
        apply_s = enter_high_s && pend_valid_r;
        if (apply_s) begin
            high_sel_s = pend_high_r;
        end else begin
            high_sel_s = act_high_r;
        end
    end

    // One-deep pending-config slot; cfg_ready mirrors its emptiness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            cfg_ready    <= 1'b1;
            pend_high_r  <= CNT_ONE;
            pend_low_r   <= CNT_ONE;
        end else if (accept_s) begin
            pend_high_r  <= clamp_min1(cfg_high);
            pend_low_r   <= clamp_min1(cfg_low);
            pend_valid_r <= 1'b1;
            cfg_ready    <= 1'b0;
        end else if (apply_s) begin
            pend_valid_r <= 1'b0;
            cfg_ready    <= 1'b1;
        end
    end

    // Active setting and its period, loaded only at the apply point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_high_r <= DEF_HIGH_C;
            act_low_r  <= DEF_LOW_C;
            cur_period <= DEF_PERIOD;
        end else if (apply_s) begin
            act_high_r <= pend_high_r;
            act_low_r  <= pend_low_r;
            cur_period <= {1'b0, pend_high_r} + {1'b0, pend_low_r};
        end
    end

    // Waveform FSM: down-counts each phase and drives the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            clk_out    <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        state_r    <= ST_HIGH;
                        clk_out    <= 1'b1;
                        rise_pulse <= 1'b1;
                        busy       <= 1'b1;
                        cnt_r      <= high_sel_s - CNT_ONE;
                    end else begin
                        clk_out <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (cnt_zero_s) begin
                        state_r    <= ST_LOW;
                        clk_out    <= 1'b0;
                        fall_pulse <= 1'b1;
                        cnt_r      <= act_low_r - CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (!cnt_zero_s) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (en) begin
                        // Seamless next period; high_sel_s picks up any pending config.
                        state_r    <= ST_HIGH;
                        clk_out    <= 1'b1;
                        rise_pulse <= 1'b1;
                        cnt_r      <= high_sel_s - CNT_ONE;
                    end else begin
                        state_r <= ST_IDLE;
                        clk_out <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    clk_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_period_gen
//
// Directed and randomized stimulus for clk_period_gen. The reference model
// tracks the waveform as "position within the current period" plus the active
// and pending settings, and derives every expected output from that position.
// -----------------------------------------------------------------------------
module tb_clk_period_gen;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_high = 16'd0;
    logic [CNT_W-1:0] cfg_low = 16'd0;
    logic             clk_out;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W:0]   cur_period;
    logic             busy;

    clk_period_gen #(.CNT_W(CNT_W), .DEF_HIGH(10), .DEF_LOW(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_high   (cfg_high),
        .cfg_low    (cfg_low),
        .clk_out    (clk_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .cur_period (cur_period),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state
    bit m_run;
    bit m_pend;
    bit last_acc;
    int m_pos;
    int m_high;
    int m_low;
    int m_ph;
    int m_pl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int clamp1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_pend = 1'b0;
        m_pos  = 0;
        m_high = 10;
        m_low  = 10;
        last_acc = 1'b0;
    endtask

    task automatic start_period();
        if (m_pend) begin
            m_high = m_ph;
            m_low  = m_pl;
            m_pend = 1'b0;
        end
        m_run = 1'b1;
        m_pos = 0;
    endtask

    // Advance the model by one clk edge using the inputs seen at that edge.
    task automatic model_edge();
        bit acc;
        acc = cfg_valid && !m_pend;
        if (!m_run) begin
            if (en) start_period();
        end else begin
            m_pos++;
            if (m_pos == m_high + m_low) begin
                if (en) begin
                    start_period();
                end else begin
                    m_run = 1'b0;
                    m_pos = 0;
                end
            end
        end
        if (acc) begin
            m_pend = 1'b1;
            m_ph   = clamp1(int'(cfg_high));
            m_pl   = clamp1(int'(cfg_low));
        end
        last_acc = acc;
    endtask

    task automatic check_all();
        check("clk_out",    32'(clk_out),    32'(m_run && (m_pos < m_high)));
        check("rise_pulse", 32'(rise_pulse), 32'(m_run && (m_pos == 0)));
        check("fall_pulse", 32'(fall_pulse), 32'(m_run && (m_pos == m_high)));
        check("busy",       32'(busy),       32'(m_run));
        check("cfg_ready",  32'(cfg_ready),  32'(!m_pend));
        check("cur_period", 32'(cur_period), 32'(m_high + m_low));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_all();
    endtask

    // Hold an offer until the model accepts it (bounded).
    task automatic offer(input int h, input int l, input string tag,
                         output int waited, output bit prev_rise);
        cfg_valid = 1'b1;
        cfg_high  = 16'(h);
        cfg_low   = 16'(l);
        waited    = 0;
        prev_rise = 1'b0;
        for (int i = 0; i < 100; i++) begin
            prev_rise = rise_pulse;
            step();
            waited++;
            if (last_acc) break;
        end
        cfg_valid = 1'b0;
        check(tag, 32'(last_acc), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise_q[$];
        int fall_q[$];
        int ready_a[0:63];
        int per_a[0:63];
        int waited;
        bit prev_rise;
        bit prev_clk;
        bit found;
        int hi;
        int lo;
        int n;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_clk_out",    32'(clk_out),    32'd0);
        check("rst_rise",       32'(rise_pulse), 32'd0);
        check("rst_fall",       32'(fall_pulse), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_cfg_ready",  32'(cfg_ready),  32'd1);
        check("rst_cur_period", 32'(cur_period), 32'd20);
        model_reset();

        // Defaults, then cfg 3/2 offered so it is sampled at edge 5
        #20;
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (cyc == 4) begin
                cfg_valid = 1'b1;
                cfg_high  = 16'd3;
                cfg_low   = 16'd2;
            end
            step();
            if (cyc == 5) cfg_valid = 1'b0;
            if (rise_pulse) rise_q.push_back(cyc);
            if (fall_pulse) fall_q.push_back(cyc);
            ready_a[cyc] = int'(cfg_ready);
            per_a[cyc]   = int'(cur_period);
        end
        check("rise_count", 32'(rise_q.size()), 32'd5);
        check("rise_0",     32'(rise_q[0]), 32'd1);
        check("rise_1",     32'(rise_q[1]), 32'd21);
        check("rise_2",     32'(rise_q[2]), 32'd26);
        check("rise_3",     32'(rise_q[3]), 32'd31);
        check("fall_0",     32'(fall_q[0]), 32'd11);
        check("fall_1",     32'(fall_q[1]), 32'd24);
        check("ready_c5",   32'(ready_a[5]),  32'd0);
        check("ready_c20",  32'(ready_a[20]), 32'd0);
        check("ready_c21",  32'(ready_a[21]), 32'd1);
        check("period_c20", 32'(per_a[20]), 32'd20);
        check("period_c21", 32'(per_a[21]), 32'd5);

        // Second config held off while one is pending; then 0/0 clamps to 1/1
        offer(2, 3, "acc_a", waited, prev_rise);
        offer(0, 0, "acc_b", waited, prev_rise);
        check("b_held_off",    32'(waited > 1), 32'd1);
        check("b_after_apply", 32'(prev_rise),  32'd1);
        for (int i = 0; i < 16; i++) step();
        for (int i = 0; i < 6; i++) begin
            prev_clk = clk_out;
            step();
            check("toggle",     32'(clk_out),    32'(!prev_clk));
            check("alt_strobe", 32'(rise_pulse), 32'(clk_out));
        end
        check("clamp_period", 32'(cur_period), 32'd2);

        // en dropped during the high phase of a 4/4 period
        offer(4, 4, "acc_44", waited, prev_rise);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (rise_pulse && (cur_period == 17'd8)) begin
                found = 1'b1;
                break;
            end
        end
        check("found_44_rise", 32'(found), 32'd1);
        en = 1'b0;
        hi = 1;
        lo = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (clk_out) hi++;
            else if (busy) lo++;
        end
        check("drop_high_len", 32'(hi), 32'd4);
        check("drop_low_len",  32'(lo), 32'd4);
        check("drop_idle_busy", 32'(busy),    32'd0);
        check("drop_idle_clk",  32'(clk_out), 32'd0);

        // Randomized enables and configs, source holds each offer until taken
        for (int i = 0; i < 400; i++) begin
            if (!cfg_valid && ($urandom_range(0, 3) == 0)) begin
                cfg_valid = 1'b1;
                cfg_high  = 16'($urandom_range(0, 6));
                cfg_low   = 16'($urandom_range(0, 6));
            end
            en = ($urandom_range(0, 7) != 0);
            step();
            if (last_acc) cfg_valid = 1'b0;
        end

        // Reset asserted mid-LOW with a pending config
        en        = 1'b1;
        cfg_valid = 1'b1;
        cfg_high  = 16'd5;
        cfg_low   = 16'd5;
        found     = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (m_run && (m_pos >= m_high) && m_pend) begin
                found = 1'b1;
                break;
            end
        end
        check("found_low_pend", 32'(found), 32'd1);
        cfg_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("mrst_clk_out",    32'(clk_out),    32'd0);
        check("mrst_cfg_ready",  32'(cfg_ready),  32'd1);
        check("mrst_cur_period", 32'(cur_period), 32'd20);
        check("mrst_busy",       32'(busy),       32'd0);
        model_reset();
        #2 rst_n = 1'b1;
        step();
        check("mrst_first_rise", 32'(rise_pulse), 32'd1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (rise_pulse) break;
        end
        check("mrst_period", 32'(n), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
